shift_add_mul14_ctrl: RTL and testbench

- Sequencer and datapath for a 14x14-bit unsigned shift-add multiplier producing a 28-bit product.
- It sits directly upstream of the mod-14 iteration counter. It drives that counter's clr/load/en inputs and consumes its co.
- The counter loads 2 and raises co at 15, which gives exactly 14 add/shift steps per multiply.
- Start/done handshake toward the host controller. The product is held until the next start.

---
 rtl/shift_add_mul14_ctrl.sv | 120 ++++++++++++
 tb/tb_shift_add_mul14_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul14_ctrl.sv
`default_nettype none
// ============================================================================
// shift_add_mul14_ctrl : 14x14 unsigned shift-add multiplier, sequencer + datapath
// Rev 1.0
// ============================================================================
module shift_add_mul14_ctrl #(
   parameter int WATCHDOG = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] a,
   input  logic [13:0] b,
   input  logic        cnt_co,
   output logic        cnt_clr,
   output logic        cnt_load,
   output logic        cnt_en,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [27:0] product
);

   localparam int WD_W = $clog2(WATCHDOG) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [13:0]     mcand;
   logic [13:0]     q;
   logic [14:0]     acc;
   logic [14:0]     sum;
   logic [28:0]     shifted;
   logic [WD_W-1:0] wd;
   logic            wd_expired;
   logic            calc_exit;

   // acc[14] is always 0 after a shift, so adding the full acc equals adding acc[13:0]
   always_comb begin
      sum        = acc + {1'b0, (q[0] ? mcand : 14'd0)};
      shifted    = {sum, q} >> 1;
      wd_expired = (wd == WD_W'(WATCHDOG - 1));
      calc_exit  = cnt_co || wd_expired;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_CALC;
         S_CALC:  if (calc_exit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      ready    = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            ready   = 1'b1;
            cnt_clr = 1'b1;
         end
         S_LOAD:  cnt_load = 1'b1;
         S_CALC:  cnt_en   = 1'b1;
         S_DONE:  done     = 1'b1;
         default: ;
      endcase
   end

   // Product is captured from the final step's shift result so it is valid during DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand   <= '0;
         q       <= '0;
         acc     <= '0;
         wd      <= '0;
         err     <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) err <= 1'b0;
            end
            S_LOAD: begin
               mcand <= a;
               q     <= b;
               acc   <= '0;
               wd    <= '0;
            end
            S_CALC: begin
               acc <= shifted[28:14];
               q   <= shifted[13:0];
               wd  <= wd + 1'b1;
               if (calc_exit) product <= shifted[27:0];
               if (!cnt_co && wd_expired) err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul14_ctrl.sv
`default_nettype none
// ============================================================================
// tb_shift_add_mul14_ctrl : bench for shift_add_mul14_ctrl with a mod-14 counter model
// Rev 1.0
// ============================================================================
module tb_shift_add_mul14_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] a = '0;
   logic [13:0] b = '0;
   logic        cnt_co;
   logic        cnt_clr, cnt_load, cnt_en, ready, done, err;
   logic [27:0] product;

   logic [3:0]  cnt = 4'd0;
   logic        stub = 1'b0;
   int          checks = 0;
   int          passes = 0;
   logic [27:0] sb[$];

   shift_add_mul14_ctrl #(.WATCHDOG(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cnt_co(cnt_co),
      .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_en(cnt_en), .ready(ready),
      .done(done), .err(err), .product(product)
   );

   always #5 clk = ~clk;

   // Iteration counter: clear to 0, load 2, carry-out at 15; stub forces co low
   always @(posedge clk) begin
      if (cnt_clr)       cnt <= 4'd0;
      else if (cnt_load) cnt <= 4'd2;
      else if (cnt_en)   cnt <= cnt + 4'd1;
   end
   assign cnt_co = !stub && (cnt == 4'd15);

   task automatic do_mul(input logic [13:0] x, input logic [13:0] y, input logic [27:0] exp,
                         output logic [27:0] prod, output logic e,
                         output int nload, output int nen, output int lat);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      sb.push_back(exp);
      prod = '0; e = 1'b0; nload = 0; nen = 0; lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (cnt_load) nload++;
         if (cnt_en)   nen++;
         if (done) begin
            prod = product; e = err; lat = i;
            break;
         end
      end
   endtask

   function automatic logic [27:0] sb_pop();
      if (sb.size() == 0) return 28'hFFFFFFF;
      return sb.pop_front();
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 14'd99; b = 14'd77;
      repeat (2) @(negedge clk);
      checks++; if (product !== 28'd0) $display("FAIL reset_product: got %0d expected 0", product); else passes++;
      checks++; if (ready !== 1'b1)    $display("FAIL reset_ready: got %b expected 1", ready); else passes++;
      checks++; if (cnt_clr !== 1'b1)  $display("FAIL reset_cnt_clr: got %b expected 1", cnt_clr); else passes++;
      checks++; if (done !== 1'b0)     $display("FAIL reset_done: got %b expected 0", done); else passes++;
      checks++; if (err !== 1'b0)      $display("FAIL reset_err: got %b expected 0", err); else passes++;
      checks++; if ({cnt_load, cnt_en} !== 2'b00) $display("FAIL reset_load_en: got %b expected 00", {cnt_load, cnt_en}); else passes++;
      rst_n = 1'b1; start = 1'b0;
   endtask

   task automatic test_basic();
      logic [27:0] p, exp; logic e; int nl, ne, lat;
      do_mul(14'd3, 14'd5, 28'd15, p, e, nl, ne, lat);
      exp = sb_pop();
      checks++; if (p !== exp)  $display("FAIL basic_product: got %0d expected %0d", p, exp); else passes++;
      checks++; if (e !== 1'b0) $display("FAIL basic_err: got %b expected 0", e); else passes++;
      checks++; if (nl != 1)    $display("FAIL basic_load_cycles: got %0d expected 1", nl); else passes++;
      checks++; if (ne != 14)   $display("FAIL basic_en_cycles: got %0d expected 14", ne); else passes++;
      checks++; if (lat != 16)  $display("FAIL basic_latency: got %0d expected 16", lat); else passes++;
      @(negedge clk);
      checks++; if ({ready, done} !== 2'b10) $display("FAIL basic_return_idle: got %b expected 10", {ready, done}); else passes++;
      checks++; if (product !== 28'd15) $display("FAIL basic_hold: got %0d expected 15", product); else passes++;
   endtask

   task automatic test_corners();
      int xs[5]   = '{16383, 0,     16383, 1,     255};
      int ys[5]   = '{16383, 12345, 1,     16383, 129};
      int exps[5] = '{268402689, 0, 16383, 16383, 32895};
      logic [27:0] p, exp; logic e; int nl, ne, lat;
      for (int k = 0; k < 5; k++) begin
         do_mul(14'(xs[k]), 14'(ys[k]), 28'(exps[k]), p, e, nl, ne, lat);
         exp = sb_pop();
         checks++; if (p !== exp) $display("FAIL corner_product[%0d]: got %0d expected %0d", k, p, exp); else passes++;
         checks++; if (e !== 1'b0 || lat != 16) $display("FAIL corner_timing[%0d]: err %b lat %0d expected 0/16", k, e, lat); else passes++;
      end
   endtask

   task automatic test_back_to_back();
      int d0 = 0, d1 = 0, phase = 0;
      logic [27:0] exp;
      @(negedge clk);
      a = 14'd100; b = 14'd200; start = 1'b1;
      sb.push_back(28'd20000);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (cnt_en && phase == 0) begin
            a = 14'd7; b = 14'd9; phase = 1;
            sb.push_back(28'd63);
         end
         if (cnt_load && d0 != 0) start = 1'b0;
         if (done) begin
            exp = sb_pop();
            checks++; if (product !== exp) $display("FAIL b2b_product: got %0d expected %0d", product, exp); else passes++;
            if (d0 == 0) d0 = i;
            else begin
               d1 = i;
               break;
            end
         end
      end
      start = 1'b0;
      checks++; if (d1 - d0 != 17 || d1 == 0) $display("FAIL b2b_spacing: got %0d expected 17", d1 - d0); else passes++;
   endtask

   task automatic test_watchdog();
      logic [27:0] p, exp; logic e; int nl, ne, lat;
      stub = 1'b1;
      // 3x5 run for two extra steps: {acc,Q} goes 15 -> 1:8199 -> 2:4099
      do_mul(14'd3, 14'd5, 28'd36867, p, e, nl, ne, lat);
      exp = sb_pop();
      checks++; if (ne != 16)   $display("FAIL wd_en_cycles: got %0d expected 16", ne); else passes++;
      checks++; if (e !== 1'b1) $display("FAIL wd_err: got %b expected 1", e); else passes++;
      checks++; if (lat != 18)  $display("FAIL wd_latency: got %0d expected 18", lat); else passes++;
      checks++; if (p !== exp)  $display("FAIL wd_product: got %0d expected %0d", p, exp); else passes++;
      @(negedge clk);
      checks++; if (err !== 1'b1) $display("FAIL wd_err_held: got %b expected 1", err); else passes++;
      stub = 1'b0;
      do_mul(14'd3, 14'd5, 28'd15, p, e, nl, ne, lat);
      exp = sb_pop();
      checks++; if (e !== 1'b0) $display("FAIL wd_err_cleared: got %b expected 0", e); else passes++;
      checks++; if (p !== exp)  $display("FAIL wd_recover_product: got %0d expected %0d", p, exp); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [27:0] p, exp; logic e; int nl, ne, lat;
      int n = 0;
      @(negedge clk);
      a = 14'd3; b = 14'd5; start = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (cnt_en) n++;
         if (n == 6) break;
      end
      checks++; if (n != 6) $display("FAIL mid_reach_calc6: got %0d expected 6", n); else passes++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (ready !== 1'b1)     $display("FAIL mid_ready: got %b expected 1", ready); else passes++;
      checks++; if (product !== 28'd0)  $display("FAIL mid_product: got %0d expected 0", product); else passes++;
      checks++; if (cnt_en !== 1'b0)    $display("FAIL mid_cnt_en: got %b expected 0", cnt_en); else passes++;
      do_mul(14'd3, 14'd5, 28'd15, p, e, nl, ne, lat);
      exp = sb_pop();
      checks++; if (p !== exp || ne != 14) $display("FAIL mid_rerun: got %0d/%0d expected %0d/14", p, ne, exp); else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_back_to_back();
      test_watchdog();
      test_reset_mid();
      checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got %0d/%0d checks expected completion", passes, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
